mux8_serializer: RTL and testbench



---
 rtl/mux8_serializer.sv | 146 ++++++++++++++
 tb/tb_mux8_serializer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux8_serializer.sv
// Parallel-to-serial stage around Mux8Way: walks the mux selects across a captured byte
// and streams the selected bit over valid/ready. Define MUX8_SER_PARITY_EN to append an even-parity bit.

module Mux8Way (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic out
);

  // s0 is the most significant select bit
  always_comb begin
    out = i0;
    case ({s0, s1, s2})
      3'd0:    out = i0;
      3'd1:    out = i1;
      3'd2:    out = i2;
      3'd3:    out = i3;
      3'd4:    out = i4;
      3'd5:    out = i5;
      3'd6:    out = i6;
      default: out = i7;
    endcase
  end

endmodule

module mux8_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic [2:0] sel,
  output logic       done
);

`ifdef MUX8_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     state;
  logic [7:0] data_q;
  logic [2:0] idx;
  logic       mux_out;

  Mux8Way u_mux (
    .i0  (data_q[0]),
    .i1  (data_q[1]),
    .i2  (data_q[2]),
    .i3  (data_q[3]),
    .i4  (data_q[4]),
    .i5  (data_q[5]),
    .i6  (data_q[6]),
    .i7  (data_q[7]),
    .s0  (idx[2]),
    .s1  (idx[1]),
    .s2  (idx[0]),
    .out (mux_out)
  );

  assign sel = idx;

`ifdef MUX8_SER_PARITY_EN
  assign bit_out = (state == PARITY) ? ^data_q : mux_out;
`else
  assign bit_out = mux_out;
`endif

  // Handshake flags are registered alongside the state so reset clears them asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= 8'd0;
      idx        <= 3'd0;
      load_ready <= 1'b1;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            data_q     <= load_data;
            idx        <= FIRST_IDX;
            state      <= SHIFT;
            load_ready <= 1'b0;
            bit_valid  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_valid && bit_ready) begin
            if (idx == LAST_IDX) begin
`ifdef MUX8_SER_PARITY_EN
              state <= PARITY;
`else
              state      <= IDLE;
              load_ready <= 1'b1;
              bit_valid  <= 1'b0;
              done       <= 1'b1;
`endif
            end else if (MSB_FIRST) begin
              idx <= idx - 3'd1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef MUX8_SER_PARITY_EN
        PARITY: begin
          if (bit_valid && bit_ready) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            bit_valid  <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          bit_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed bench for mux8_serializer: one LSB-first and one MSB-first instance share clock and reset.
// Parity-bit checks are compiled in when MUX8_SER_PARITY_EN is defined.

module tb_mux8_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv0, lv1, br0, br1;
  logic [7:0] ld0, ld1;
  logic       lr0, lr1, bo0, bo1, bv0, bv1, dn0, dn1;
  logic [2:0] sl0, sl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
    .bit_out(bo0), .bit_valid(bv0), .bit_ready(br0), .sel(sl0), .done(dn0)
  );

  mux8_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
    .bit_out(bo1), .bit_valid(bv1), .bit_ready(br1), .sel(sl1), .done(dn1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input logic v, input logic [7:0] d, input logic r);
    if (m) begin lv1 = v; ld1 = d; br1 = r; end
    else   begin lv0 = v; ld0 = d; br0 = r; end
  endtask

  task automatic check_outs(input bit m, input string tag, input logic v, input logic [2:0] s,
                            input logic b);
    check({tag, ".valid"}, m ? bv1 : bv0, {7'd0, v});
    check({tag, ".sel"},   m ? {5'd0, sl1} : {5'd0, sl0}, {5'd0, s});
    check({tag, ".bit"},   m ? bo1 : bo0, {7'd0, b});
  endtask

  // Streams one word; stall_k/abort_k/intrude_k name the bit position (-1 = unused)
  task automatic send(input bit m, input logic [7:0] w, input int stall_k, input int abort_k,
                      input int intrude_k);
    logic [2:0] i;
    check("load_ready_pre", m ? lr1 : lr0, 8'd1);
    drive(m, 1'b1, w, 1'b1);
    step();
    drive(m, 1'b0, ~w, 1'b1);
    for (int k = 0; k < 8; k++) begin
      i = m ? 3'(7 - k) : 3'(k);
      check_outs(m, "data", 1'b1, i, w[i]);
      check("busy_ready", m ? lr1 : lr0, 8'd0);
      if (k == intrude_k) drive(m, 1'b1, 8'hFF, 1'b1);
      else                drive(m, 1'b0, ~w, 1'b1);
      if (k == abort_k) begin
        #2 reset = 1'b1;
        #1;
        check_outs(m, "rst", 1'b0, 3'd0, 1'b0);
        check("rst.ready", m ? lr1 : lr0, 8'd1);
        check("rst.done",  m ? dn1 : dn0, 8'd0);
        #2 reset = 1'b0;
        step();
        check("abort.done",  m ? dn1 : dn0, 8'd0);
        check("abort.valid", m ? bv1 : bv0, 8'd0);
        return;
      end
      if (k == stall_k) begin
        drive(m, 1'b0, ~w, 1'b0);
        repeat (3) begin
          step();
          check_outs(m, "stall", 1'b1, i, w[i]);
          check("stall.done", m ? dn1 : dn0, 8'd0);
        end
        drive(m, 1'b0, ~w, 1'b1);
      end
      step();
    end
`ifdef MUX8_SER_PARITY_EN
    check_outs(m, "parity", 1'b1, m ? 3'd0 : 3'd7, ^w);
    check("parity.done", m ? dn1 : dn0, 8'd0);
    step();
`endif
    check("done",       m ? dn1 : dn0, 8'd1);
    check("done.ready", m ? lr1 : lr0, 8'd1);
    check("done.valid", m ? bv1 : bv0, 8'd0);
    step();
    check("done_pulse", m ? dn1 : dn0, 8'd0);
    check("idle.valid", m ? bv1 : bv0, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    step();
    check_outs(1'b0, "reset0", 1'b0, 3'd0, 1'b0);
    check("reset0.ready", lr0, 8'd1);
    check("reset0.done",  dn0, 8'd0);
    check_outs(1'b1, "reset1", 1'b0, 3'd0, 1'b0);

    send(1'b0, 8'hA5, -1, -1, -1);
    send(1'b0, 8'hA5,  2, -1, -1);
    send(1'b1, 8'h01, -1, -1,  3);
    send(1'b0, 8'hF0, -1,  4, -1);
    send(1'b0, 8'h3C, -1, -1, -1);
    send(1'b0, 8'h07, -1, -1, -1);
    send(1'b0, 8'h03, -1, -1, -1);
    send(1'b1, 8'h07, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
